// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Stall/flush sequencer for the 5-stage core. It owns the PC, IF/ID and
//   ID/EX pipeline-register controls:
//     - load-use hazard between ID and EX  -> 1-cycle stall with ID/EX bubble
//     - multi-cycle EX op (mul/div)        -> front end frozen, ID/EX held
//                                             for MULTI_LAT-1 cycles, then
//                                             released in a LAST cycle
//     - branch taken in ID                 -> IF/ID flush
//
// Optional feature macro: STALL_PERF_EN
//   Defined   : stall_cnt_o / flush_cnt_o are live wrapping counters.
//   Undefined : both ports are tied to zero and no counter flops exist.
//
// Parameters
//   MULTI_LAT  EX occupancy of a multi-cycle op in cycles (2..17)
//   CNT_W      busy-counter width, must hold MULTI_LAT-2
//   PERF_W     performance counter width
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active-high
//   id_valid_i       IF/ID holds a real instruction
//   id_rs_i/id_rt_i  IF/ID source register fields
//   ex_memread_i     ID/EX MemRead control bit
//   ex_rt_i          ID/EX load destination register
//   ex_multi_i       ID/EX holds a multi-cycle op
//   branch_taken_i   branch resolved taken in ID
//   pc_write_o       PC write-enable
//   ifid_write_o     IF/ID write-enable
//   ifid_flush_o     IF/ID flush (NOP insert)
//   idex_bubble_o    load zeroed controls into ID/EX
//   idex_hold_o      ID/EX keeps its contents
//   multi_done_o     final EX cycle of a multi-cycle op
//   stall_cnt_o      stalled-cycle count
//   flush_cnt_o      flush count
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MULTI_LAT = 4,
  parameter int CNT_W     = 4,
  parameter int PERF_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [4:0]        id_rs_i,
  input  logic [4:0]        id_rt_i,
  input  logic              ex_memread_i,
  input  logic [4:0]        ex_rt_i,
  input  logic              ex_multi_i,
  input  logic              branch_taken_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              idex_hold_o,
  output logic              multi_done_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] MULTI = 2'd1;
  localparam logic [1:0] LAST  = 2'd2;

  // Counter preload on entry to MULTI; MULTI occupies MULTI_LAT-2 cycles.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (MULTI_LAT > 2) ? CNT_W'(MULTI_LAT - 3) : '0;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_hazard;
  logic             w_eval;

  assign w_hazard = id_valid_i & ex_memread_i & (ex_rt_i != 5'd0) &
                    ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

  // Hazard/branch evaluation happens in RUN (no multi pending) and in LAST,
  // where a still-asserted ex_multi_i belongs to the op being retired.
  assign w_eval = ((r_state == RUN) & ~ex_multi_i) | (r_state == LAST);

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    idex_hold_o   = 1'b0;
    multi_done_o  = 1'b0;
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;

    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      w_next_state  = RUN;
      w_next_cnt    = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_multi_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_hold_o  = 1'b1;
            if (MULTI_LAT > 2) begin
              w_next_state = MULTI;
              w_next_cnt   = CNT_INIT;
            end else begin
              w_next_state = LAST;
            end
          end
        end
        MULTI: begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          idex_hold_o  = 1'b1;
          if (r_cnt == '0) begin
            w_next_state = LAST;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
        LAST: begin
          multi_done_o = 1'b1;
          w_next_state = RUN;
        end
        default: begin
          w_next_state = RUN;
          w_next_cnt   = '0;
        end
      endcase

      // A stall beats a flush: branch operands are not ready yet.
      if (w_eval) begin
        if (w_hazard) begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

`ifdef STALL_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_write_o) begin
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      end
      if (ifid_flush_o) begin
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
